println: RTL and testbench

// - Formats a 16-bit unsigned integer as decimal ASCII text, followed by CR LF.
// - Emits the text one character per clock as a byte stream with a valid strobe.
// - Sits between the RPN calculator result path and the UART transmit FIFO.
// - Leading zeros are suppressed; the value 0 prints as a single "0".
//

---
 rtl/println_pkg.sv | 38 +++
 rtl/println_bin2bcd16.sv | 26 ++
 rtl/println.sv | 117 +++++++++++
 tb/tb_println.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/println_pkg.sv
// Shared definitions for the println decimal-line formatter.
//   - ASCII constants for the digit base and the line terminator.
//   - FSM state and CR/LF phase encodings.
//   - first_digit(): index (0 = ten-thousands .. 4 = units) of the first
//     nonzero BCD digit, falling back to the units digit for zero.
package println_pkg;

  localparam logic [7:0] ZERO = 8'h30;
  localparam logic [7:0] CR   = 8'h0D;
  localparam logic [7:0] LF   = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EMIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PH_DIGIT = 2'd0,
    PH_CR    = 2'd1,
    PH_LF    = 2'd2
  } phase_e;

  function automatic logic [2:0] first_digit(input logic [19:0] bcd);
    logic [2:0] idx;
    logic       found;
    idx   = 3'd4;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && (bcd[19 - 4*i -: 4] != 4'd0)) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/println_bin2bcd16.sv
// Combinational 16-bit binary to 5-digit BCD converter (double dabble).
//   bin : input  [15:0] unsigned value, 0..65535
//   bcd : output [19:0] five BCD digits, [19:16] = ten-thousands .. [3:0] = units
module bin2bcd16 (
  input  logic [15:0] bin,
  output logic [19:0] bcd
);

  logic [35:0] sh;

  // BCD field lives in sh[35:16]; before each shift, any digit >= 5 gets +3
  // so the shift carries correctly into the next decimal digit.
  always_comb begin
    sh = {20'd0, bin};
    for (int unsigned i = 0; i < 16; i++) begin
      for (int unsigned j = 0; j < 5; j++) begin
        if (sh[16 + 4*j +: 4] >= 4'd5) begin
          sh[16 + 4*j +: 4] = sh[16 + 4*j +: 4] + 4'd3;
        end
      end
      sh = sh << 1;
    end
    bcd = sh[35:16];
  end

endmodule

// File: rtl/println.sv
// Prints a 16-bit unsigned value as decimal ASCII followed by CR LF, one
// character per clock, leading zeros suppressed ("0" for zero).
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   byte_in : value to print, sampled when wen is accepted in IDLE
//   wen     : one-cycle print request; ignored while busy
//   dout    : current ASCII character, held while idle
//   ready   : one-cycle strobe marking a new character on dout
module println
  import println_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] byte_in,
  input  logic        wen,
  output logic [7:0]  dout,
  output logic        ready
);

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [15:0] value_q, value_d;
  logic [19:0] bcd_q,   bcd_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  dout_q,  dout_d;
  logic        ready_q, ready_d;

  logic [19:0] bcd_w;
  logic [3:0]  digit;

  bin2bcd16 u_bin2bcd16 (
    .bin (value_q),
    .bcd (bcd_w)
  );

  always_comb begin
    digit = 4'd0;
    case (idx_q)
      3'd0:    digit = bcd_q[19:16];
      3'd1:    digit = bcd_q[15:12];
      3'd2:    digit = bcd_q[11:8];
      3'd3:    digit = bcd_q[7:4];
      default: digit = bcd_q[3:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    value_d = value_q;
    bcd_d   = bcd_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (wen) begin
          value_d = byte_in;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d   = bcd_w;
        idx_d   = first_digit(bcd_w);
        phase_d = PH_DIGIT;
        state_d = EMIT;
      end
      EMIT: begin
        ready_d = 1'b1;
        case (phase_q)
          PH_DIGIT: begin
            dout_d = ZERO + {4'd0, digit};
            if (idx_q == 3'd4) begin
              phase_d = PH_CR;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
          PH_CR: begin
            dout_d  = CR;
            phase_d = PH_LF;
          end
          default: begin
            dout_d  = LF;
            phase_d = PH_DIGIT;
            state_d = IDLE;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= PH_DIGIT;
      value_q <= '0;
      bcd_q   <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      value_q <= value_d;
      bcd_q   <= bcd_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
    end
  end

  assign dout  = dout_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_println.sv
module tb_println;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] byte_in = 16'd0;
  logic        wen = 1'b0;
  logic [7:0]  dout;
  logic        ready;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected line for the current scenario; index k of the log is the k-th
  // rising edge after the edge that sampled wen.
  logic [7:0] exp_c [0:6];
  int         exp_len;
  logic       rdy_log [1:12];
  logic [7:0] ch_log  [1:12];

  println dut (
    .clk     (clk),
    .rst     (rst),
    .byte_in (byte_in),
    .wen     (wen),
    .dout    (dout),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  // Issue one wen pulse, then log 12 edges of output.
  task automatic send_and_log(input logic [15:0] v);
    @(negedge clk);
    byte_in = v;
    wen     = 1'b1;
    @(posedge clk);
    #1;
    wen     = 1'b0;
    byte_in = 16'hBEEF;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      rdy_log[k] = ready;
      ch_log[k]  = dout;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ready cyc%0d: got %b want 0", k, ready);
      end
      n_cmp++;
      if (dout !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_dout cyc%0d: got %h want 00", k, dout);
      end
    end
  endtask

  task automatic test_max();
    exp_c[0] = 8'h36; exp_c[1] = 8'h35; exp_c[2] = 8'h35; exp_c[3] = 8'h33;
    exp_c[4] = 8'h35; exp_c[5] = 8'h0D; exp_c[6] = 8'h0A; exp_len = 7;
    send_and_log(16'd65535);
    for (int k = 1; k <= 12; k++) begin
      n_cmp++;
      if (rdy_log[k] !== ((k >= 2) && (k < 2 + exp_len))) begin
        n_fail++;
        $display("FAIL max_ready k%0d: got %b", k, rdy_log[k]);
      end
      if (k >= 2) begin
        n_cmp++;
        if (ch_log[k] !== exp_c[(k < 2 + exp_len) ? k - 2 : exp_len - 1]) begin
          n_fail++;
          $display("FAIL max_dout k%0d: got %h", k, ch_log[k]);
        end
      end
    end
  endtask

  task automatic test_123();
    exp_c[0] = 8'h31; exp_c[1] = 8'h32; exp_c[2] = 8'h33; exp_c[3] = 8'h0D;
    exp_c[4] = 8'h0A; exp_len = 5;
    send_and_log(16'd123);
    for (int k = 1; k <= 12; k++) begin
      n_cmp++;
      if (rdy_log[k] !== ((k >= 2) && (k < 2 + exp_len))) begin
        n_fail++;
        $display("FAIL v123_ready k%0d: got %b", k, rdy_log[k]);
      end
      if (k >= 2) begin
        n_cmp++;
        if (ch_log[k] !== exp_c[(k < 2 + exp_len) ? k - 2 : exp_len - 1]) begin
          n_fail++;
          $display("FAIL v123_dout k%0d: got %h", k, ch_log[k]);
        end
      end
    end
  endtask

  task automatic test_zero();
    exp_c[0] = 8'h30; exp_c[1] = 8'h0D; exp_c[2] = 8'h0A; exp_len = 3;
    send_and_log(16'd0);
    for (int k = 1; k <= 12; k++) begin
      n_cmp++;
      if (rdy_log[k] !== ((k >= 2) && (k < 2 + exp_len))) begin
        n_fail++;
        $display("FAIL zero_ready k%0d: got %b", k, rdy_log[k]);
      end
      if (k >= 2) begin
        n_cmp++;
        if (ch_log[k] !== exp_c[(k < 2 + exp_len) ? k - 2 : exp_len - 1]) begin
          n_fail++;
          $display("FAIL zero_dout k%0d: got %h", k, ch_log[k]);
        end
      end
    end
  endtask

  task automatic test_embedded_zeros();
    exp_c[0] = 8'h31; exp_c[1] = 8'h30; exp_c[2] = 8'h30; exp_c[3] = 8'h30;
    exp_c[4] = 8'h30; exp_c[5] = 8'h0D; exp_c[6] = 8'h0A; exp_len = 7;
    send_and_log(16'd10000);
    for (int k = 1; k <= 12; k++) begin
      n_cmp++;
      if (rdy_log[k] !== ((k >= 2) && (k < 2 + exp_len))) begin
        n_fail++;
        $display("FAIL v10000_ready k%0d: got %b", k, rdy_log[k]);
      end
      if (k >= 2) begin
        n_cmp++;
        if (ch_log[k] !== exp_c[(k < 2 + exp_len) ? k - 2 : exp_len - 1]) begin
          n_fail++;
          $display("FAIL v10000_dout k%0d: got %h", k, ch_log[k]);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    exp_c[0] = 8'h37; exp_c[1] = 8'h0D; exp_c[2] = 8'h0A; exp_len = 3;
    @(negedge clk);
    byte_in = 16'd7;
    wen     = 1'b1;
    @(posedge clk);
    #1;
    wen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) begin
        byte_in = 16'd99;
        wen     = 1'b1;
      end
      @(posedge clk);
      #1;
      wen        = 1'b0;
      rdy_log[k] = ready;
      ch_log[k]  = dout;
    end
    for (int k = 1; k <= 12; k++) begin
      n_cmp++;
      if (rdy_log[k] !== ((k >= 2) && (k < 2 + exp_len))) begin
        n_fail++;
        $display("FAIL busy_ready k%0d: got %b", k, rdy_log[k]);
      end
      if (k >= 2) begin
        n_cmp++;
        if (ch_log[k] !== exp_c[(k < 2 + exp_len) ? k - 2 : exp_len - 1]) begin
          n_fail++;
          $display("FAIL busy_dout k%0d: got %h", k, ch_log[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    byte_in = 16'd65535;
    wen     = 1'b1;
    @(posedge clk);
    #1;
    wen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) rst = 1'b1;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      rdy_log[k] = ready;
      ch_log[k]  = dout;
    end
    n_cmp++;
    if (ch_log[3] !== 8'h35) begin
      n_fail++;
      $display("FAIL rstmid_2nd_char: got %h want 35", ch_log[3]);
    end
    for (int k = 4; k <= 12; k++) begin
      n_cmp++;
      if (rdy_log[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_ready k%0d: got %b want 0", k, rdy_log[k]);
      end
      n_cmp++;
      if (ch_log[k] !== 8'h00) begin
        n_fail++;
        $display("FAIL rstmid_dout k%0d: got %h want 00", k, ch_log[k]);
      end
    end
    exp_c[0] = 8'h35; exp_c[1] = 8'h0D; exp_c[2] = 8'h0A; exp_len = 3;
    send_and_log(16'd5);
    for (int k = 1; k <= 12; k++) begin
      n_cmp++;
      if (rdy_log[k] !== ((k >= 2) && (k < 2 + exp_len))) begin
        n_fail++;
        $display("FAIL after_rst_ready k%0d: got %b", k, rdy_log[k]);
      end
      if (k >= 2) begin
        n_cmp++;
        if (ch_log[k] !== exp_c[(k < 2 + exp_len) ? k - 2 : exp_len - 1]) begin
          n_fail++;
          $display("FAIL after_rst_dout k%0d: got %h", k, ch_log[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_123();
    test_zero();
    test_embedded_zeros();
    test_busy_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
